// File: rtl/sum4bit_seq_ctrl.sv
// Multi-nibble adder built by time-sharing one 4-bit adder: per nibble, one pass for
// the operands and one pass to fold in the rippled carry, least-significant nibble first.
`timescale 1ns/1ps

module sum4bit (
   input  logic [3:0] x0,
   input  logic [3:0] x1,
   output logic [4:0] o
);
   assign o = {1'b0, x0} + {1'b0, x1};
endmodule

module sum4bit_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADD   = 2'd1;
   localparam logic [1:0] S_CARRY = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          cin_q, cin_d;
   logic [3:0]    p_q, p_d;
   logic          c1_q, c1_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;

   logic [3:0]    a_nib, b_nib;
   logic [3:0]    add_x0, add_x1;
   logic [4:0]    add_o;
   logic          last_nib;

   sum4bit u_adder (
      .x0 (add_x0),
      .x1 (add_x1),
      .o  (add_o)
   );

   // Nibble select as a compare-per-nibble mux so non-power-of-two widths stay clean
   always_comb begin
      a_nib = 4'd0;
      b_nib = 4'd0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end
   end

   assign last_nib = (idx_q == IW'(NIBBLES - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      cin_d   = cin_q;
      p_d     = p_q;
      c1_d    = c1_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      add_x0  = 4'd0;
      add_x1  = 4'd0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
               cin_d   = 1'b0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            add_x0  = a_nib;
            add_x1  = b_nib;
            p_d     = add_o[3:0];
            c1_d    = add_o[4];
            state_d = S_CARRY;
         end
         S_CARRY: begin
            add_x0 = p_q;
            add_x1 = {3'b000, cin_q};
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IW'(i)) sum_d[4*i +: 4] = add_o[3:0];
            end
            // p <= 14 whenever c1 is set, so the two carries never coincide
            cin_d = c1_q | add_o[4];
            if (last_nib) begin
               cout_d  = c1_q | add_o[4];
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_ADD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cin_q   <= 1'b0;
         p_q     <= 4'd0;
         c1_q    <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         cin_q   <= cin_d;
         p_q     <= p_d;
         c1_q    <= c1_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_sum4bit_seq_ctrl.sv
// Randomized and directed checks of the nibble-serial adder sequencer against plain
// arithmetic (A+B) and the fixed 2*NIBBLES latency.
`timescale 1ns/1ps

module tb_sum4bit_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4, busy4, done4, cout4;
   logic [15:0] a4, b4, sum4;
   logic        start1, busy1, done1, cout1;
   logic [3:0]  a1, b1, sum1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sum4bit_seq_ctrl #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   sum4bit_seq_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   // Launches one op on the 4-nibble instance and records what it observed.
   task automatic op4(input logic [15:0] av, input logic [15:0] bv,
                      output logic [15:0] s, output logic c, output int lat,
                      output int bcnt, output bit clr, output bit pulse_ok);
      @(negedge clk);
      a4 = av; b4 = bv; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      a4 = 16'($urandom); b4 = 16'($urandom);
      clr = (sum4 === 16'h0000) && (cout4 === 1'b0);
      bcnt = busy4 ? 1 : 0;
      lat = -1; s = 'x; c = 1'bx; pulse_ok = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (busy4) bcnt++;
         if (done4 && lat < 0) begin
            lat = k; s = sum4; c = cout4;
         end
         if (!busy4) begin
            pulse_ok = !done4;
            break;
         end
      end
   endtask

   task automatic test_op(input string name, input logic [15:0] av, input logic [15:0] bv);
      logic [16:0] exp;
      logic [15:0] s;
      logic        c;
      int          lat, bcnt;
      bit          clr, pulse_ok;
      exp = {1'b0, av} + {1'b0, bv};
      op4(av, bv, s, c, lat, bcnt, clr, pulse_ok);
      checks++;
      if ({c, s} !== exp) begin
         failures++;
         $display("FAIL %s result: a=%h b=%h got cout=%b sum=%h expected cout=%b sum=%h",
                  name, av, bv, c, s, exp[16], exp[15:0]);
      end
      checks++;
      if (lat !== 8) begin
         failures++;
         $display("FAIL %s latency: got %0d expected 8", name, lat);
      end
      checks++;
      if (bcnt !== 9) begin
         failures++;
         $display("FAIL %s busy_cycles: got %0d expected 9", name, bcnt);
      end
      checks++;
      if (!clr) begin
         failures++;
         $display("FAIL %s clear_on_start: got sum=%h cout=%b expected 0", name, sum4, cout4);
      end
      checks++;
      if (!pulse_ok) begin
         failures++;
         $display("FAIL %s done_pulse: done=%b expected single-cycle pulse", name, done4);
      end
      $display("op %s a=%h b=%h sum=%h cout=%b lat=%0d", name, av, bv, s, c, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0;
      a4 = '0; b4 = '0; a1 = '0; b1 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy4, done4, cout4, sum4, busy1, done1, cout1, sum1} !== '0) begin
         failures++;
         $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b expected zeros",
                  busy4, done4, sum4, cout4);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_directed();
      test_op("basic", 16'h1234, 16'h4321);
      test_op("ripple", 16'hFFFF, 16'h0001);
      test_op("allones", 16'hFFFF, 16'hFFFF);
      test_op("zeros", 16'h0000, 16'h0000);
   endtask

   task automatic test_hold();
      test_op("hold", 16'hA5C3, 16'h7E19);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({cout4, sum4} !== 17'h123DC) begin
         failures++;
         $display("FAIL hold_result: got cout=%b sum=%h expected cout=1 sum=23dc", cout4, sum4);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) test_op("random", 16'($urandom), 16'($urandom));
   endtask

   task automatic test_ignore_start();
      int          ndone;
      logic [15:0] s;
      logic        c;
      ndone = 0; s = 'x; c = 1'bx;
      @(negedge clk);
      a4 = 16'h0001; b4 = 16'h0001; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (done4) begin
            ndone++; s = sum4; c = cout4;
         end
         start4 = (k == 2 || k == 4);
         if (start4) begin
            a4 = 16'($urandom); b4 = 16'($urandom);
         end
      end
      checks++;
      if (ndone !== 1) begin
         failures++;
         $display("FAIL ignore_start_count: got %0d done pulses expected 1", ndone);
      end
      checks++;
      if ({c, s} !== 17'h00002) begin
         failures++;
         $display("FAIL ignore_start_result: got cout=%b sum=%h expected cout=0 sum=0002", c, s);
      end
      $display("op ignore_start dones=%0d sum=%h cout=%b", ndone, s, c);
   endtask

   task automatic test_back_to_back();
      logic [15:0] av, bv;
      logic [16:0] exp;
      int          t1, t2, ndone, nbad;
      av = 16'($urandom); bv = 16'($urandom);
      exp = {1'b0, av} + {1'b0, bv};
      t1 = -1; t2 = -1; ndone = 0; nbad = 0;
      @(negedge clk);
      a4 = av; b4 = bv; start4 = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done4) begin
            ndone++;
            if ({cout4, sum4} !== exp) nbad++;
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
         end
      end
      start4 = 1'b0;
      for (int k = 0; k < 30 && busy4; k++) @(posedge clk);
      #1;
      checks++;
      if (t1 !== 8) begin
         failures++;
         $display("FAIL b2b_first_done: got %0d expected 8", t1);
      end
      checks++;
      if (t2 - t1 !== 10) begin
         failures++;
         $display("FAIL b2b_spacing: got %0d expected 10", t2 - t1);
      end
      checks++;
      if (ndone < 2 || nbad !== 0) begin
         failures++;
         $display("FAIL b2b_results: got %0d dones %0d wrong expected >=2 dones 0 wrong", ndone, nbad);
      end
      checks++;
      if (busy4 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: got busy=%b expected 0", busy4);
      end
      $display("op back_to_back a=%h b=%h dones=%0d t1=%0d t2=%0d", av, bv, ndone, t1, t2);
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      a4 = 16'h00F0; b4 = 16'h0010; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy4, done4, cout4, sum4} !== '0) begin
         failures++;
         $display("FAIL abort_reset: got busy=%b done=%b sum=%h cout=%b expected zeros",
                  busy4, done4, sum4, cout4);
      end
      @(negedge clk) rst_n = 1'b1;
      test_op("after_abort", 16'h0100, 16'h0200);
      test_op("pre_idle_reset", 16'h1234, 16'h4321);
      @(negedge clk) rst_n = 1'b0;
      #1;
      checks++;
      if ({cout4, sum4} !== '0) begin
         failures++;
         $display("FAIL idle_reset_clear: got sum=%h cout=%b expected 0", sum4, cout4);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_nib1_exhaustive();
      int   lat, nbad_sum, nbad_lat;
      logic [4:0] got;
      nbad_sum = 0; nbad_lat = 0;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            a1 = 4'(i); b1 = 4'(j); start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            lat = -1; got = 'x;
            for (int k = 1; k <= 10; k++) begin
               @(posedge clk); #1;
               if (done1 && lat < 0) begin
                  lat = k; got = {cout1, sum1};
               end
               if (!busy1) break;
            end
            checks++;
            if (got !== 5'(i + j)) begin
               failures++; nbad_sum++;
               $display("FAIL nib1_result: i=%0d j=%0d got %0d expected %0d", i, j, got, i + j);
            end
            checks++;
            if (lat !== 2) begin
               failures++; nbad_lat++;
               $display("FAIL nib1_latency: i=%0d j=%0d got %0d expected 2", i, j, lat);
            end
         end
      end
      $display("op nib1_exhaustive pairs=256 bad_sum=%0d bad_lat=%0d", nbad_sum, nbad_lat);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_nib1_exhaustive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
